// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the instruction SRAM; loads a program from the host, then streams it to the decoder.
// A skid FIFO absorbs the SRAM's one-cycle read latency so that backpressure never loses a word.
module inst_fetch_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int FIFO_D = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  output logic              load_ready,
  input  logic              start,
  output logic [ADDR_W:0]   prog_len,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              busy,
  output logic              done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_A,
  output logic [DATA_W-1:0] sram_D,
  input  logic [DATA_W-1:0] sram_Q
);
  localparam int PW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW = $clog2(FIFO_D + 1);
  localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_D);
  localparam logic [PW-1:0] L_PTR_MAX = PW'(FIFO_D - 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_LOAD = 2'd1, S_FETCH = 2'd2, S_DRAIN = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_prog_len;
  logic [ADDR_W:0]   r_pc;
  logic [ADDR_W-1:0] r_pc_d;
  logic              r_inflight;
  logic              r_done;
  logic [DATA_W-1:0] r_fifo_d  [FIFO_D];
  logic [ADDR_W-1:0] r_fifo_pc [FIFO_D];
  logic [PW-1:0]     r_head;
  logic [PW-1:0]     r_tail;
  logic [CW-1:0]     r_count;

  logic              w_beat;
  logic              w_issue;
  logic              w_last_issue;
  logic              w_push;
  logic              w_pop;
  logic              w_end_load;
  logic [CW:0]       w_occ;

  // Occupancy counts the read still in the SRAM pipe so a push can never find the FIFO full.
  assign w_occ        = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_beat       = (r_state == S_LOAD) && load_valid;
  assign w_issue      = (r_state == S_FETCH) && (r_pc < r_prog_len) && (w_occ < L_DEPTH);
  assign w_last_issue = w_issue && (r_pc == r_prog_len - (ADDR_W+1)'(1));
  assign w_end_load   = w_beat && (load_last || (r_wr_ptr == {ADDR_W{1'b1}}));
  assign w_push       = r_inflight;
  assign w_pop        = inst_valid && inst_ready;

  assign load_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign prog_len   = r_prog_len;
  assign inst_valid = (r_count != '0);
  assign inst_data  = inst_valid ? r_fifo_d[r_head] : '0;
  assign inst_pc    = inst_valid ? r_fifo_pc[r_head] : '0;
  assign sram_ceb   = !(w_beat || w_issue);
  assign sram_web   = !w_beat;
  assign sram_A     = w_beat ? r_wr_ptr : w_issue ? r_pc[ADDR_W-1:0] : '0;
  assign sram_D     = w_beat ? load_data : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_prog_len <= '0;
      r_pc       <= '0;
      r_pc_d     <= '0;
      r_inflight <= 1'b0;
      r_done     <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_pc_d <= r_pc[ADDR_W-1:0];
        r_pc   <= r_pc + (ADDR_W+1)'(1);
      end
      if (w_push) begin
        r_fifo_d[r_tail]  <= sram_Q;
        r_fifo_pc[r_tail] <= r_pc_d;
        r_tail            <= (r_tail == L_PTR_MAX) ? '0 : r_tail + PW'(1);
      end
      if (w_pop)
        r_head <= (r_head == L_PTR_MAX) ? '0 : r_head + PW'(1);
      r_count <= (w_push && !w_pop) ? r_count + CW'(1) :
                 (w_pop && !w_push) ? r_count - CW'(1) : r_count;
      case (r_state)
        S_IDLE: begin
          if (load_start) begin
            r_state  <= S_LOAD;
            r_wr_ptr <= '0;
          end else if (start) begin
            if (r_prog_len == '0) r_done <= 1'b1;
            else begin
              r_state <= S_FETCH;
              r_pc    <= '0;
            end
          end
        end
        S_LOAD: begin
          if (w_beat) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
          if (w_end_load) begin
            r_prog_len <= {1'b0, r_wr_ptr} + (ADDR_W+1)'(1);
            r_state    <= S_IDLE;
          end
        end
        S_FETCH: if (w_last_issue) r_state <= S_DRAIN;
        default: begin
          if (!r_inflight && (r_count == '0)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: drives loads and fetches against a behavioural SRAM and a program-image reference.
module tb_inst_fetch_ctrl;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic          start = 1'b0, inst_ready = 1'b0;
  logic [DW-1:0] load_data = '0;
  logic          load_ready, inst_valid, busy, done, sram_ceb, sram_web;
  logic [AW:0]   prog_len;
  logic [DW-1:0] inst_data, sram_D, sram_Q;
  logic [AW-1:0] inst_pc, sram_A;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sram [32];
  logic [DW-1:0] rd_q = '0;
  logic [DW-1:0] junk = 32'h8000_0000;
  logic          rd_v = 1'b0;
  logic [DW-1:0] ref_mem [32];
  int            ref_len = 0;

  always #5 clk = ~clk;

  inst_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
    .load_last(load_last), .load_ready(load_ready),
    .start(start), .prog_len(prog_len),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .busy(busy), .done(done),
    .sram_ceb(sram_ceb), .sram_web(sram_web), .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  // Behavioural SRAM: registered read, garbage (bit 31 set) whenever no read was issued last cycle.
  always @(posedge clk) begin
    if (!sram_ceb && !sram_web) sram[sram_A] <= sram_D;
    if (!sram_ceb && sram_web) rd_q <= sram[sram_A];
    rd_v <= !sram_ceb && sram_web;
    junk <= 32'h8000_0000 | $urandom;
  end
  assign sram_Q = rd_v ? rd_q : junk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({sram_ceb, sram_web, load_ready, inst_valid, busy, done} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl got=%b want=110000", {sram_ceb, sram_web, load_ready, inst_valid, busy, done});
    end
    checks++;
    if ({sram_A, sram_D, inst_data, inst_pc, prog_len} !== '0) begin
      errors++;
      $display("FAIL reset_data A=%0h D=%0h data=%0h pc=%0d len=%0d want all 0", sram_A, sram_D, inst_data, inst_pc, prog_len);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_prog(input int n, input bit use_last, input int base);
    int i;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL load_enter ready=%b busy=%b want 1 1", load_ready, busy);
    end
    i = 0;
    while (i < n) begin
      if (base == 0 && $urandom_range(3) == 0) begin
        load_valid = 1'b0;
        #1;
        checks++;
        if (sram_ceb !== 1'b1) begin
          errors++;
          $display("FAIL load_gap ceb=%b want 1", sram_ceb);
        end
        tick();
        continue;
      end
      load_valid = 1'b1;
      load_data  = (base != 0) ? DW'(base + i) : ($urandom & 32'h7FFF_FFFF);
      load_last  = use_last && (i == n - 1);
      #1;
      checks++;
      if ({sram_ceb, sram_web, sram_A, sram_D} !== {2'b00, i[AW-1:0], load_data}) begin
        errors++;
        $display("FAIL load_beat%0d ceb=%b web=%b A=%0d D=%0h want 0 0 %0d %0h", i, sram_ceb, sram_web, sram_A, sram_D, i, load_data);
      end
      ref_mem[i] = load_data;
      tick();
      i++;
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    ref_len    = n;
    #1;
    checks++;
    if (load_ready !== 1'b0 || busy !== 1'b0 || prog_len !== (AW+1)'(n)) begin
      errors++;
      $display("FAIL load_exit ready=%b busy=%b len=%0d want 0 0 %0d", load_ready, busy, prog_len, n);
    end
  endtask

  // mode 0: always ready, 1: stalled for `stall` cycles, 2: random ready
  task automatic run_fetch(input int mode, input int stall);
    int exp_pc, c, first_v, last_pop, stall_reads;
    bit fin, prev_stall;
    logic [DW-1:0] prev_d;
    logic [AW-1:0] prev_pc;
    exp_pc = 0; first_v = -1; last_pop = -1; stall_reads = 0; fin = 0; prev_stall = 0;
    prev_d = '0; prev_pc = '0;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 1;
    while (!fin && c < 400) begin
      inst_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c > stall) : 1'($urandom_range(1));
      #1;
      if (inst_valid && first_v < 0) first_v = c;
      if (mode == 1 && c <= stall && !sram_ceb) stall_reads++;
      if (prev_stall) begin
        checks++;
        if (inst_valid !== 1'b1 || inst_data !== prev_d || inst_pc !== prev_pc) begin
          errors++;
          $display("FAIL hold c=%0d v=%b pc=%0d data=%0h want 1 %0d %0h", c, inst_valid, inst_pc, inst_data, prev_pc, prev_d);
        end
      end
      if (done) begin
        fin = 1;
        checks++;
        if (exp_pc != ref_len || busy !== 1'b0 || sram_ceb !== 1'b1) begin
          errors++;
          $display("FAIL done_state delivered=%0d busy=%b ceb=%b want %0d 0 1", exp_pc, busy, sram_ceb, ref_len);
        end
      end
      if (inst_valid && inst_ready) begin
        checks++;
        if (exp_pc >= ref_len || inst_pc !== exp_pc[AW-1:0] || inst_data !== ref_mem[exp_pc]) begin
          errors++;
          $display("FAIL deliver%0d pc=%0d data=%0h want %0d %0h", exp_pc, inst_pc, inst_data, exp_pc, ref_mem[exp_pc % 32]);
        end
        exp_pc++;
        last_pop = c;
      end
      prev_stall = inst_valid && !inst_ready;
      prev_d = inst_data;
      prev_pc = inst_pc;
      tick();
      c++;
    end
    inst_ready = 1'b0;
    #1;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL fetch_timeout delivered=%0d want %0d", exp_pc, ref_len);
    end
    checks++;
    if (exp_pc != ref_len) begin
      errors++;
      $display("FAIL fetch_count got=%0d want %0d", exp_pc, ref_len);
    end
    checks++;
    if (done !== 1'b0 || sram_ceb !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done done=%b ceb=%b busy=%b want 0 1 0", done, sram_ceb, busy);
    end
    if (mode == 0) begin
      checks++;
      if (first_v != 3 || last_pop != ref_len + 2) begin
        errors++;
        $display("FAIL latency first_valid=%0d last_pop=%0d want 3 %0d", first_v, last_pop, ref_len + 2);
      end
    end
    if (mode == 1) begin
      checks++;
      if (stall_reads > 3) begin
        errors++;
        $display("FAIL stall_reads got=%0d want <=3", stall_reads);
      end
    end
  endtask

  task automatic test_zero_len;
    start = 1'b1;
    #1;
    checks++;
    if (sram_ceb !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_ceb got=%b want 1", sram_ceb);
    end
    tick();
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || sram_ceb !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_done done=%b busy=%b ceb=%b want 1 0 1", done, busy, sram_ceb);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_pulse done=%b want 0", done);
    end
    load_start = 1'b1;
    start = 1'b1;
    tick();
    load_start = 1'b0;
    start = 1'b0;
    checks++;
    if (load_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL both_start ready=%b busy=%b want 1 1", load_ready, busy);
    end
    load_valid = 1'b1;
    load_last = 1'b1;
    load_data = 32'h0000_0055;
    ref_mem[0] = load_data;
    ref_len = 1;
    tick();
    load_valid = 1'b0;
    load_last = 1'b0;
    checks++;
    if (prog_len !== 6'd1 || load_ready !== 1'b0) begin
      errors++;
      $display("FAIL both_start_len len=%0d ready=%b want 1 0", prog_len, load_ready);
    end
    run_fetch(0, 0);
  endtask

  task automatic test_reset_mid_fetch;
    int c;
    load_prog(20, 1'b1, 0);
    inst_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    c = 0;
    while (c < 40) begin
      #1;
      if (!sram_ceb && sram_A == 5'd5) break;
      tick();
      c++;
    end
    checks++;
    if (c >= 40) begin
      errors++;
      $display("FAIL mid_fetch_timeout A=%0d want 5", sram_A);
    end
    rst_n = 1'b0;
    tick();
    inst_ready = 1'b0;
    #1;
    checks++;
    if ({sram_ceb, sram_web, load_ready, inst_valid, busy, done} !== 6'b110000 ||
        {sram_A, sram_D, inst_data, inst_pc, prog_len} !== '0) begin
      errors++;
      $display("FAIL mid_reset ctrl=%b A=%0d data=%0h pc=%0d len=%0d want 110000 0 0 0 0",
               {sram_ceb, sram_web, load_ready, inst_valid, busy, done}, sram_A, inst_data, inst_pc, prog_len);
    end
    rst_n = 1'b1;
    tick();
    load_prog(2, 1'b1, 0);
    run_fetch(0, 0);
  endtask

  initial begin
    test_reset();
    test_zero_len();
    load_prog(4, 1'b1, 32'hA0);
    run_fetch(0, 0);
    load_prog(32, 1'b0, 0);
    run_fetch(0, 0);
    load_prog(8, 1'b1, 0);
    run_fetch(1, 10);
    load_prog(20, 1'b1, 0);
    run_fetch(2, 0);
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Controller sitting directly in front of the 32x32 instruction SRAM, owning all of its ports (ceb, web, A, D, Q).
- LOAD phase: streams a program from the host interface into SRAM words 0..N-1.
- FETCH phase: reads words 0..N-1 in order and presents each to the downstream decoder through a valid/ready handshake, absorbing the SRAM's 1-cycle registered read latency with a small skid FIFO.

Parameters:
- ADDR_W, 5, SRAM address width.
- DATA_W, 32, instruction width.
- FIFO_D, 3, skid FIFO depth; 3 is the minimum for full throughput.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- load_start  in  1  pulse; enter LOAD from IDLE.
- load_valid  in  1  host write beat valid.
- load_data  in  DATA_W  instruction word to write.
- load_last  in  1  qualifies the final beat of a load.
- load_ready  out  1  high while in LOAD.
- start  in  1  pulse; begin fetch from IDLE.
- prog_len  out  ADDR_W+1  number of words loaded (0..32).
- inst_valid  out  1  FIFO head valid.
- inst_ready  in  1  decoder accepts the head.
- inst_data  out  DATA_W  head instruction.
- inst_pc  out  ADDR_W  SRAM address of the head instruction.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a fetch pass completes.
- sram_ceb  out  1  SRAM chip enable, active low.
- sram_web  out  1  SRAM write enable, active low.
- sram_A  out  ADDR_W  SRAM address.
- sram_D  out  DATA_W  SRAM write data.
- sram_Q  in  DATA_W  SRAM read data; valid only the cycle after a read was issued, high-Z otherwise.

Behaviour:
- Reset: state = IDLE, sram_ceb = 1, sram_web = 1, sram_A = 0, sram_D = 0, load_ready = 0, inst_valid = 0, inst_data = 0, inst_pc = 0, busy = 0, done = 0, prog_len = 0. FIFO is flushed, inflight = 0, pointers = 0.
- Reset asserted mid-LOAD or mid-FETCH aborts to these values on the next edge. SRAM contents are not touched.
- States: IDLE, LOAD, FETCH, DRAIN.
- IDLE transitions:
  - load_start -> LOAD with wr_ptr = 0.
  - start -> FETCH with pc = 0, but if prog_len == 0, pulse done and stay IDLE.
  - load_start and start together: load_start wins.
- LOAD:
  - load_ready = 1.
  - A beat is load_valid & load_ready. On a beat, drive sram_ceb = 0, sram_web = 0, sram_A = wr_ptr, sram_D = load_data in that same cycle; this path is combinational from load_valid/load_data. wr_ptr increments.
  - Beat with load_last: prog_len <= wr_ptr + 1, go to IDLE.
  - Beat at wr_ptr == 31 without load_last: prog_len <= 32, go to IDLE; the wrap is never written.
  - start and load_start are ignored in LOAD.
- FETCH, read issue:
  - Issue a read when pc < prog_len and (fifo_count + inflight) < FIFO_D.
  - On issue: sram_ceb = 0, sram_web = 1, sram_A = pc, pc increments.
  - These SRAM outputs depend only on registers, with no combinational path from inst_ready.
  - When no issue, sram_ceb = 1.
  - After the last address (prog_len - 1) is issued, go to DRAIN.
- FETCH, capture:
  - inflight <= issue. pc_d <= pc of the issued read.
  - When inflight = 1, push {sram_Q, pc_d} into the FIFO on that edge.
  - sram_Q is never sampled when inflight = 0.
- FIFO:
  - Push and pop in the same cycle is legal; count is unchanged.
  - Overflow is impossible by the issue rule.
  - inst_valid = FIFO not empty; inst_data and inst_pc are the FIFO head.
  - Pop on inst_valid & inst_ready.
  - inst_data and inst_pc hold stable while inst_valid & !inst_ready.
- DRAIN: no issue. When inflight = 0 and FIFO empty, pulse done for 1 cycle and go to IDLE.
- Latency: start sampled at edge T; first read issued in cycle T+1; Q valid in cycle T+2; inst_valid high from cycle T+3.
- Throughput: with inst_ready held high, 1 instruction/cycle sustained.
- start or load_start received in FETCH or DRAIN is ignored.
- SRAM idle (sram_ceb = 1) in IDLE and DRAIN.
- busy = 1 in LOAD, FETCH, DRAIN.

Test Plan:
- Load 4 words 0xA0..0xA3 (load_last on 4th), start, inst_ready = 1 -> prog_len = 4; inst_valid from start+3; outputs (pc, data) = (0,A0),(1,A1),(2,A2),(3,A3) on consecutive cycles; done pulses once; sram_ceb = 1 afterwards.
- Load 32 words without load_last -> auto-exit to IDLE with prog_len = 32; fetch returns all 32 in order, pc 0..31, no wrap.
- Backpressure: prog_len = 8, inst_ready = 0 for 10 cycles then 1 -> at most 3 reads issued while stalled; head held as (0, word0); all 8 delivered in order, none lost or duplicated.
- Random inst_ready toggling over prog_len = 20 -> exact ordered sequence; sram_Q never captured when no read was issued the previous cycle (drive sram_Q = X when not read).
- start with prog_len = 0 -> done pulse the next cycle, no SRAM access; load_start and start in the same cycle -> enters LOAD.
- rst_n = 0 mid-FETCH at pc = 5 -> next edge: all outputs at reset values, FIFO empty; reload 2 words and fetch returns the new data.
